md_sched: RTL and testbench
===========================

# md_sched

Multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage and models fixed instruction latency with a busy countdown. At completion it commits the result to HI/LO. It also raises the D-stage stall request so that any HI/LO-touching instruction waits until the unit is free.

## Interface
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU; legal range 1..15.
- clk  input  1: rising-edge clock.
- reset  input  1: asynchronous, active-low reset.
- start  input  1: E-stage md instruction valid this cycle.
- op  input  3: operation, encoded per package (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- a  input  32: rs value (GPR[rs]).
- b  input  32: rt value (GPR[rt]); ignored for MTHI/MTLO.
- d_uses_md  input  1: D-stage instruction is any of MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- busy  output  1: a multiply or divide is in flight.
- stall  output  1: stall request to the hazard unit.
- hi  output  32: architectural HI register.
- lo  output  32: architectural LO register.

## Operation
- Reset (reset=0, async): state IDLE, counter 0, busy 0, hi 0, lo 0, pending result cleared. stall follows its equation below.
- States:
  - IDLE:
    - start with a multiply or divide op: capture op, compute and latch the 64-bit result in pending {hi,lo}.
    - Load counter with MULT_CYCLES or DIV_CYCLES, then go to RUN.
  - RUN: decrement counter each cycle. When counter==1, write pending to hi/lo and go to IDLE.
- MTHI/MTLO: single-cycle write of `a` to hi/lo at the edge ending the start cycle. No busy.
- Arithmetic:
  - MULT: signed 32x32 into a 64-bit product; hi=[63:32], lo=[31:0].
  - MULTU: same as MULT, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - DIVU: same as DIV, unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (DIV or DIVU): run the full DIV_CYCLES with busy; hi/lo unchanged at commit.
- stall = d_uses_md & (busy | (start & op is multiply/divide)).
- start while busy is a protocol violation, since stall prevents it. It is ignored: no state change and hi/lo untouched.
- Pipeline flush is not an input. An md instruction that reached E always completes.

## Timing
- start asserted in cycle t (multiply/divide) → busy=1 in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
- New hi/lo visible in cycle t+N+1, the same cycle busy drops.
- A back-to-back start in cycle t+N+1 is accepted.
- MTHI/MTLO at cycle t → hi/lo updated and visible in t+1.
- busy, hi and lo are registered outputs. stall is combinational from registered busy plus the start/op/d_uses_md inputs.
- Reset asserted mid-RUN: busy drops immediately (async), the pending result is discarded, and hi=lo=0.
- The result is computed at issue. Operands a/b need not be held after cycle t.

## Structure
- Shared package md_pkg holds:
  - op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - state encodings: IDLE, RUN.
  - the 4-bit counter width.
- One combinational sub-module, md_calc: inputs op, a, b; outputs result[63:0] and div_zero. It holds all signed/unsigned arithmetic and the special cases.
- md_sched holds the FSM, counter, pending register, HI/LO registers and the stall logic.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 at t → busy in t+1..t+5; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at t+6.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- hi=0x11, lo=0x22 preset via MTHI/MTLO, then DIVU b=0 → busy 10 cycles, hi=0x11, lo=0x22 after completion. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU start at t with d_uses_md=1 held → stall=1 in t..t+5 and 0 at t+6. With d_uses_md=0 → stall=0 throughout.
- reset pulled low at t+3 of a DIV → busy=0 and hi=lo=0 within the same cycle. After release, a new MULT 6×7 gives lo=42, hi=0 after 5 cycles.
- start pulsed at t+2 during a MULT with a different op/operands → ignored; final hi/lo match the original MULT and busy length is unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler.
//   - md_op_e    : E-stage md operation encodings
//   - md_state_e : scheduler FSM states
//   - CNT_W/XLEN : busy-counter and datapath widths
//   - is_muldiv  : true for ops that occupy the unit for multiple cycles
package md_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned XLEN  = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Multiply and divide ops are encoded below MTHI/MTLO.
  function automatic logic is_muldiv(input logic [2:0] op);
    return op <= 3'(MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath.
// Ports:
//   op       in  3   operation (md_op_e encoding)
//   a        in  32  rs operand / dividend
//   b        in  32  rt operand / divisor
//   result   out 64  {hi, lo}: product, or {remainder, quotient}
//   div_zero out 1   DIV/DIVU with a zero divisor (result must not be committed)
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] result,
  output logic              div_zero
);

  logic              signed_div;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   q_mag;
  logic [XLEN-1:0]   r_mag;
  logic [XLEN-1:0]   q_res;
  logic [XLEN-1:0]   r_res;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
  assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  // Signed divide is done on magnitudes, then signs are restored; this keeps
  // 0x80000000 / -1 well defined (quotient wraps back to 0x80000000).
  assign signed_div = (op == MD_DIV);
  assign mag_a = (signed_div && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
  assign mag_b = (signed_div && b[XLEN-1]) ? (~b + XLEN'(1)) : b;
  assign q_mag = (b == '0) ? '0 : (mag_a / mag_b);
  assign r_mag = (b == '0) ? '0 : (mag_a % mag_b);

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign q_res = (signed_div && (a[XLEN-1] ^ b[XLEN-1])) ? (~q_mag + XLEN'(1)) : q_mag;
  assign r_res = (signed_div && a[XLEN-1]) ? (~r_mag + XLEN'(1)) : r_mag;

  assign div_zero = (b == '0) && ((op == MD_DIV) || (op == MD_DIVU));

  always_comb begin
    result = '0;
    case (op)
      MD_MULT:         result = prod_s;
      MD_MULTU:        result = prod_u;
      MD_DIV, MD_DIVU: result = {r_res, q_res};
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler with architectural HI/LO.
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   asynchronous active-low reset
//   start     in  1   E-stage md instruction valid
//   op        in  3   operation (md_op_e encoding)
//   a, b      in  32  rs / rt operands
//   d_uses_md in  1   D-stage instruction touches HI/LO or the md unit
//   busy      out 1   multiply/divide in flight (registered)
//   stall     out 1   D-stage stall request (combinational)
//   hi, lo    out 32  architectural HI/LO (registered)
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            d_uses_md,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e         state;
  md_state_e         next_state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  load_cnt;
  logic [2*XLEN-1:0] pend;
  logic              pend_zero;
  logic [2*XLEN-1:0] calc_result;
  logic              calc_div_zero;
  logic              issue_md;
  logic              load_c;
  logic              commit_c;
  logic              wr_hi_c;
  logic              wr_lo_c;

  md_calc u_calc (
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (calc_result),
    .div_zero (calc_div_zero)
  );

  assign issue_md = start && is_muldiv(op);
  assign load_cnt = ((op == MD_DIV) || (op == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                        : CNT_W'(MULT_CYCLES);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (issue_md) next_state = RUN;
      RUN:     if (cnt == CNT_W'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode; starts seen in RUN are dropped here
  always_comb begin
    load_c   = 1'b0;
    commit_c = 1'b0;
    wr_hi_c  = 1'b0;
    wr_lo_c  = 1'b0;
    case (state)
      IDLE: begin
        load_c  = issue_md;
        wr_hi_c = start && (op == MD_MTHI);
        wr_lo_c = start && (op == MD_MTLO);
      end
      RUN:     commit_c = (cnt == CNT_W'(1));
      default: ;
    endcase
  end

  // Counter, pending result, HI/LO and busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      pend      <= '0;
      pend_zero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
    end else begin
      if (load_c) begin
        cnt       <= load_cnt;
        pend      <= calc_result;
        pend_zero <= calc_div_zero;
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Divide by zero burns the full latency but leaves HI/LO alone.
      if (commit_c && !pend_zero) begin
        hi <= pend[2*XLEN-1:XLEN];
        lo <= pend[XLEN-1:0];
      end
      if (wr_hi_c) hi <= a;
      if (wr_lo_c) lo <= a;
      busy <= (next_state == RUN);
    end
  end

  assign stall = d_uses_md && (busy || issue_md);

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction for one cycle; operands are scrambled afterwards.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
    a     = 32'hDEADBEEF;
    b     = 32'hCAFEF00D;
  endtask

  // Count consecutive busy cycles starting now; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; d_uses_md = 1'b0;
    step(); step();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passed++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int n;
    issue(MD_MULT, 32'hFFFFFFFD, 32'd5);
    count_busy(n);
    total++; if (n !== 5) $display("FAIL mult_busy_len: got %0d expected 5", n); else passed++;
    total++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi); else passed++;
    total++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo: got %h expected fffffff1", lo); else passed++;
  endtask

  task automatic test_div();
    int n;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    total++; if (n !== 10) $display("FAIL div_busy_len: got %0d expected 10", n); else passed++;
    total++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h expected fffffffd", lo); else passed++;
    total++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h expected ffffffff", hi); else passed++;
    issue(MD_DIVU, 32'd7, 32'd2);
    count_busy(n);
    total++; if (n !== 10) $display("FAIL divu_busy_len: got %0d expected 10", n); else passed++;
    total++; if (lo !== 32'd3) $display("FAIL divu_lo: got %h expected 3", lo); else passed++;
    total++; if (hi !== 32'd1) $display("FAIL divu_hi: got %h expected 1", hi); else passed++;
  endtask

  task automatic test_div_special();
    int n;
    issue(MD_MTHI, 32'h11, 32'h0);
    total++; if (hi !== 32'h11) $display("FAIL mthi_hi: got %h expected 11", hi); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", busy); else passed++;
    issue(MD_MTLO, 32'h22, 32'h0);
    total++; if (lo !== 32'h22) $display("FAIL mtlo_lo: got %h expected 22", lo); else passed++;
    issue(MD_DIVU, 32'd5, 32'd0);
    count_busy(n);
    total++; if (n !== 10) $display("FAIL divzero_busy_len: got %0d expected 10", n); else passed++;
    total++; if (hi !== 32'h11) $display("FAIL divzero_hi: got %h expected 11", hi); else passed++;
    total++; if (lo !== 32'h22) $display("FAIL divzero_lo: got %h expected 22", lo); else passed++;
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    total++; if (n !== 10) $display("FAIL divovf_busy_len: got %0d expected 10", n); else passed++;
    total++; if (lo !== 32'h80000000) $display("FAIL divovf_lo: got %h expected 80000000", lo); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL divovf_hi: got %h expected 0", hi); else passed++;
  endtask

  task automatic test_stall();
    int bad;
    d_uses_md = 1'b1;
    start = 1'b1; op = MD_MULTU; a = 32'hFFFFFFFF; b = 32'd2;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL stall_issue_cycle: got %b expected 1", stall); else passed++;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      total++; if (stall !== 1'b1) $display("FAIL stall_busy_cycle%0d: got %b expected 1", k, stall); else passed++;
      step();
    end
    total++; if (stall !== 1'b0) $display("FAIL stall_release: got %b expected 0", stall); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL stall_busy_release: got %b expected 0", busy); else passed++;
    total++; if (hi !== 32'h1) $display("FAIL multu_hi: got %h expected 1", hi); else passed++;
    total++; if (lo !== 32'hFFFFFFFE) $display("FAIL multu_lo: got %h expected fffffffe", lo); else passed++;
    d_uses_md = 1'b0;
    bad = 0;
    start = 1'b1; op = MD_MULTU; a = 32'hFFFFFFFF; b = 32'd2;
    #1;
    if (stall !== 1'b0) bad++;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (stall !== 1'b0) bad++;
      step();
    end
    total++; if (bad !== 0) $display("FAIL stall_no_d_use: got %0d stalled cycles expected 0", bad); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    issue(MD_DIV, 32'd100, 32'd7);
    step(); step();
    #1 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL midreset_hi: got %h expected 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL midreset_lo: got %h expected 0", lo); else passed++;
    step();
    reset = 1'b1;
    step();
    issue(MD_MULT, 32'd6, 32'd7);
    count_busy(n);
    total++; if (n !== 5) $display("FAIL postreset_busy_len: got %0d expected 5", n); else passed++;
    total++; if (lo !== 32'd42) $display("FAIL postreset_lo: got %h expected 2a", lo); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL postreset_hi: got %h expected 0", hi); else passed++;
  endtask

  task automatic test_ignore_busy_start();
    int n;
    issue(MD_MULT, 32'h00010000, 32'h00010000);
    total++; if (busy !== 1'b1) $display("FAIL ignore_busy_t1: got %b expected 1", busy); else passed++;
    step();
    start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd3;
    step();
    start = 1'b0;
    count_busy(n);
    total++; if (n !== 3) $display("FAIL ignore_remaining_busy: got %0d expected 3", n); else passed++;
    total++; if (hi !== 32'h1) $display("FAIL ignore_hi: got %h expected 1", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL ignore_lo: got %h expected 0", lo); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    issue(MD_MULT, 32'd3, 32'd4);
    count_busy(n);
    total++; if (n !== 5) $display("FAIL b2b_first_len: got %0d expected 5", n); else passed++;
    total++; if (lo !== 32'd12) $display("FAIL b2b_first_lo: got %h expected c", lo); else passed++;
    issue(MD_MULTU, 32'h80000000, 32'd4);
    count_busy(n);
    total++; if (n !== 5) $display("FAIL b2b_second_len: got %0d expected 5", n); else passed++;
    total++; if (hi !== 32'd2) $display("FAIL b2b_second_hi: got %h expected 2", hi); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL b2b_second_lo: got %h expected 0", lo); else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_stall();
    test_reset_mid();
    test_ignore_busy_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
